mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port data SRAM between two requesters: instruction fetch (I port, read-only) and
//  load/store (D port, read/write). Sits between ifu/exu and sram inside core.
//  Grants at most one access per cycle: fixed D-over-I priority, with an I-port starvation guard.
//  Routes each read response, in order, back to the port that issued it after RD_LAT cycles.
// PARAMETERS
//  AW          32  address width; byte address, passed through unchanged
//  DW          32  data width
//  RD_LAT      1   SRAM read latency in cycles; legal values 1 or 2
//  STARVE_MAX  3   consecutive denied I-request cycles before I is forced to win
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       asynchronous reset, active low
//  i_req     in   1       I-port read request; addr held stable until i_gnt
//  i_addr    in   AW      I-port address
//  i_gnt     out  1       I-port request accepted this cycle
//  i_rvalid  out  1       I-port read data valid
//  i_rdata   out  DW      I-port read data
//  d_req     in   1       D-port request; all D inputs held stable until d_gnt
//  d_we      in   1       1 = write, 0 = read
//  d_wmask   in   DW/8    byte write mask
//  d_addr    in   AW      D-port address
//  d_wdata   in   DW      D-port write data
//  d_gnt     out  1       D-port request accepted this cycle
//  d_rvalid  out  1       D-port response: read data valid, or write acknowledge
//  d_rdata   out  DW      D-port read data
//  m_en      out  1       SRAM access strobe
//  m_we      out  1       SRAM write enable
//  m_wmask   out  DW/8    SRAM byte enables
//  m_addr    out  AW      SRAM address
//  m_wdata   out  DW      SRAM write data
//  m_rdata   in   DW      SRAM read data, valid RD_LAT cycles after m_en
// BEHAVIOUR
//  - Grant is combinational. i_gnt & d_gnt are never both 1. A port's request is consumed on the
//    clock edge in a cycle where its gnt=1.
//  - Arbitration: if only one port requests, that port wins.
//    If both request, D wins, unless starve_cnt==STARVE_MAX, in which case I wins.
//  - starve_cnt: +1 (saturating at STARVE_MAX) when i_req & !i_gnt.
//    Cleared when i_gnt=1 or i_req=0. Reset value 0.
//  - m_*: driven from the granted port in the same cycle; m_en = i_gnt|d_gnt.
//    For an I grant, m_we=0 and m_wmask=0. With no grant, all m_* are 0.
//  - Response pipe: RD_LAT stages of {valid, port, we}, shifted every cycle, no stall. Back-to-back
//    grants are legal every cycle. Responses return strictly in issue order.
//  - Pipe output stage:
//    - I read: i_rvalid=1, i_rdata=m_rdata.
//    - D read: d_rvalid=1, d_rdata=m_rdata.
//    - D write: d_rvalid=1, d_rdata=0 (acknowledge only).
//    - rdata outputs are 0 whenever their rvalid is 0.
//  - Write timing: the SRAM commits the write at the grant edge. A read of the same address granted
//    in the next cycle returns the new data.
//  - Reset (asynchronous): while rst_n=0, i_gnt, d_gnt, m_en and m_we are forced to 0.
//    The pipe and starve_cnt clear immediately. In-flight reads are dropped: no rvalid is ever
//    produced for an access granted before reset.
//  - No errors are flagged. Misalignment is the requester's responsibility.
// STRUCTURE
//  - Package crane_mem_pkg: PORT_I=1'b0, PORT_D=1'b1; struct/typedef for a pipe entry {valid, port, we}.
//  - Sub-module mem_rsp_pipe: RD_LAT-deep shift register of pipe entries with async clear.
//  - Arbiter, starvation counter and output muxing stay in mem_arbiter.
// TESTING
//  1. rst_n=0 with i_req=d_req=1 for 5 cycles -> i_gnt=d_gnt=m_en=0, no rvalid.
//     Release -> D granted first.
//  2. i_req, addr 0x10, SRAM[0x10]=0x00000013 -> i_gnt same cycle;
//     i_rvalid=1, i_rdata=0x00000013 one cycle later (RD_LAT=1).
//  3. i_req and d_req held high for 8 cycles, STARVE_MAX=3 -> grant sequence D,D,D,I,D,D,D,I.
//  4. D write 0xDEADBEEF mask 4'b1111 @0x20, then D write 0x000000AA mask 4'b0001 @0x20,
//     then D read @0x20 -> two acks with d_rdata=0, then d_rdata=0xDEADBEAA.
//  5. I read granted, rst_n pulsed low before the response cycle -> no i_rvalid after release;
//     the next I read returns correct data.
//  6. RD_LAT=2, alternating I/D reads every cycle at distinct addresses -> each port's rvalid
//     appears exactly 2 cycles after its gnt, with matching data, in order.

Source files
------------

// File: rtl/crane_mem_pkg.sv
// Shared types for the SRAM arbiter: port ids and the
// response-pipe entry carried alongside each access.
package crane_mem_pkg;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic we;
  } rsp_ent_t;

  localparam rsp_ent_t RSP_IDLE = '{
    valid: 1'b0,
    port:  1'b0,
    we:    1'b0
  };

  function automatic rsp_ent_t rsp_ent(
    input logic port,
    input logic we
  );
    rsp_ent_t e;
    e.valid = 1'b1;
    e.port  = port;
    e.we    = we;
    return e;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-depth shift register that tracks who owns each
// outstanding SRAM access; cleared asynchronously.
module mem_rsp_pipe
  import crane_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
)(
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_ent_t i_ent,
  output rsp_ent_t o_ent
);

  rsp_ent_t r_stage [DEPTH];

  // Shift one stage per cycle; no stall path exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= RSP_IDLE;
      end
    end else begin
      r_stage[0] <= i_ent;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_ent = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between fetch (I) and
// load/store (D): D priority with an I starvation guard.
module mem_arbiter
  import crane_mem_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_wmask,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [DW/8-1:0] m_wmask,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam int unsigned MW    = DW / 8;
  localparam int unsigned DEPTH =
    (RD_LAT < 1) ? 1 : RD_LAT;
  localparam int unsigned SW    =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP =
    SW'(STARVE_MAX);

  logic [SW-1:0] r_starve;
  logic          w_starved;
  logic          w_i_win;
  logic          w_i_gnt;
  logic          w_d_gnt;
  rsp_ent_t      w_ent_in;
  rsp_ent_t      w_ent_out;

  assign w_starved = (r_starve == STARVE_TOP);

  // I wins alone, or when it has waited long enough.
  assign w_i_win = i_req & (~d_req | w_starved);

  // Grants are held off while reset is asserted so a
  // request can never be consumed during reset.
  assign w_i_gnt = rst_n & w_i_win;
  assign w_d_gnt = rst_n & d_req & ~w_i_win;

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;

  // Count consecutive cycles an I request loses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (i_req & ~w_i_gnt) begin
      if (!w_starved) begin
        r_starve <= r_starve + 1'b1;
      end
    end else begin
      r_starve <= '0;
    end
  end

  // Drive the SRAM from whichever port holds the grant.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_wmask = '0;
    m_addr  = '0;
    m_wdata = '0;
    unique case (1'b1)
      w_i_gnt: begin
        m_en   = 1'b1;
        m_addr = i_addr;
      end
      w_d_gnt: begin
        m_en    = 1'b1;
        m_we    = d_we;
        m_wmask = d_wmask;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end
      default: begin
        m_en = 1'b0;
      end
    endcase
  end

  // Tag each granted access with its owner and kind.
  always_comb begin
    w_ent_in = RSP_IDLE;
    unique case (1'b1)
      w_i_gnt: w_ent_in = rsp_ent(PORT_I, 1'b0);
      w_d_gnt: w_ent_in = rsp_ent(PORT_D, d_we);
      default: w_ent_in = RSP_IDLE;
    endcase
  end

  mem_rsp_pipe #(
    .DEPTH (DEPTH)
  ) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ent (w_ent_in),
    .o_ent (w_ent_out)
  );

  // Steer returning data; writes only acknowledge.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    if (w_ent_out.valid) begin
      if (w_ent_out.port == PORT_I) begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end else begin
        d_rvalid = 1'b1;
        if (!w_ent_out.we) begin
          d_rdata = m_rdata;
        end
      end
    end
  end

  logic [MW-1:0] w_mask_unused;
  assign w_mask_unused = d_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random
// traffic on RD_LAT=1 and RD_LAT=2 instances.
module tb_mem_arbiter;

  localparam int SM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_req    [2];
  logic [31:0] i_addr   [2];
  logic        i_gnt    [2];
  logic        i_rvalid [2];
  logic [31:0] i_rdata  [2];
  logic        d_req    [2];
  logic        d_we     [2];
  logic [3:0]  d_wmask  [2];
  logic [31:0] d_addr   [2];
  logic [31:0] d_wdata  [2];
  logic        d_gnt    [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata  [2];
  logic        m_en     [2];
  logic        m_we     [2];
  logic [3:0]  m_wmask  [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [31:0] m_rdata  [2];

  int passed = 0;
  int total  = 0;

  function automatic logic [31:0] init_word(int idx);
    if (idx == 4) return 32'h0000_0013;
    return 32'h5A00_0000 ^ (32'(idx) * 32'h0001_0203);
  endfunction

  typedef struct {
    int          due;
    bit          port;
    bit          we;
    logic [31:0] data;
  } rsp_t;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = g + 1;

    logic [31:0] mem  [256];
    logic [31:0] refm [256];
    logic [31:0] rd1;
    logic [31:0] rd2;
    rsp_t        q [$];
    int          starve = 0;
    int          cyc = 0;

    initial begin
      for (int a = 0; a < 256; a++) begin
        mem[a]  = init_word(a);
        refm[a] = init_word(a);
      end
    end

    // SRAM model: write at the grant edge, read pipelined.
    always @(posedge clk) begin
      rd2 <= rd1;
      if (m_en[g] && m_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask[g][b])
            mem[m_addr[g][9:2]][b*8 +: 8] = m_wdata[g][b*8 +: 8];
        rd1 <= $urandom;
      end else if (m_en[g]) begin
        rd1 <= mem[m_addr[g][9:2]];
      end else begin
        rd1 <= $urandom;
      end
    end

    assign m_rdata[g] = (LAT == 1) ? rd1 : rd2;

    mem_arbiter #(
      .AW(32), .DW(32), .RD_LAT(LAT), .STARVE_MAX(SM)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req[g]), .i_addr(i_addr[g]),
      .i_gnt(i_gnt[g]), .i_rvalid(i_rvalid[g]),
      .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]),
      .d_wmask(d_wmask[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]),
      .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]),
      .m_wmask(m_wmask[g]), .m_addr(m_addr[g]),
      .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g])
    );

    // Reference model: arbitration rule, memory image and
    // an in-order queue of responses due at a given cycle.
    always @(negedge clk) begin
      logic        ei, ed;
      logic [37:0] em, am;
      logic [65:0] er, ar;
      logic [31:0] ew;
      rsp_t        r;
      cyc++;
      if (!rst_n) begin
        q.delete();
        starve = 0;
        total++;
        if ({i_gnt[g], d_gnt[g], m_en[g], m_we[g],
             i_rvalid[g], d_rvalid[g]} !== 6'b0)
          $display("FAIL rst_quiet dut%0d: got %b want 000000", g,
            {i_gnt[g], d_gnt[g], m_en[g], m_we[g],
             i_rvalid[g], d_rvalid[g]});
        else passed++;
      end else begin
        ei = i_req[g] && (!d_req[g] || starve >= SM);
        ed = d_req[g] && !ei;
        total++;
        if ({i_gnt[g], d_gnt[g]} !== {ei, ed})
          $display("FAIL gnt dut%0d cyc%0d: got %b%b want %b%b",
            g, cyc, i_gnt[g], d_gnt[g], ei, ed);
        else passed++;
        em = ei ? {2'b10, 4'h0, i_addr[g]} :
             ed ? {1'b1, d_we[g], d_wmask[g], d_addr[g]} : '0;
        am = {m_en[g], m_we[g], m_wmask[g], m_addr[g]};
        total++;
        if (am !== em)
          $display("FAIL mbus dut%0d cyc%0d: got %h want %h",
            g, cyc, am, em);
        else passed++;
        if (!ei) begin
          ew = ed ? d_wdata[g] : 32'h0;
          total++;
          if (m_wdata[g] !== ew)
            $display("FAIL m_wdata dut%0d: got %h want %h",
              g, m_wdata[g], ew);
          else passed++;
        end
        er = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          r = q.pop_front();
          er = r.port ? {33'h0, 1'b1, r.data}
                      : {1'b1, r.data, 33'h0};
        end
        ar = {i_rvalid[g], i_rdata[g], d_rvalid[g], d_rdata[g]};
        total++;
        if (ar !== er)
          $display("FAIL rsp dut%0d cyc%0d: got %h want %h",
            g, cyc, ar, er);
        else passed++;
        if (ei) begin
          r.due = cyc + LAT; r.port = 1'b0; r.we = 1'b0;
          r.data = refm[i_addr[g][9:2]];
          q.push_back(r);
        end
        if (ed) begin
          r.due = cyc + LAT; r.port = 1'b1; r.we = d_we[g];
          if (d_we[g]) begin
            for (int b = 0; b < 4; b++)
              if (d_wmask[g][b])
                refm[d_addr[g][9:2]][b*8 +: 8] = d_wdata[g][b*8 +: 8];
            r.data = 32'h0;
          end else begin
            r.data = refm[d_addr[g][9:2]];
          end
          q.push_back(r);
        end
        if (i_req[g] && !ei) starve = (starve < SM) ? starve + 1 : SM;
        else starve = 0;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_wmask[k] = 4'h0; i_addr[k] = 32'h0;
      d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
    end
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1; d_req[k] = 1'b1;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({i_gnt[k], d_gnt[k], m_en[k], i_rvalid[k], d_rvalid[k]} !== 5'b0)
          $display("FAIL reset_hold dut%0d: got %b want 00000", k,
            {i_gnt[k], d_gnt[k], m_en[k], i_rvalid[k], d_rvalid[k]});
        else passed++;
      end
    end
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({i_gnt[k], d_gnt[k]} !== 2'b01)
        $display("FAIL reset_first_d dut%0d: got %b%b want 01",
          k, i_gnt[k], d_gnt[k]);
      else passed++;
    end
    nxt();
    idle_all();
    nxt();
  endtask

  task automatic test_i_read();
    i_req[0] = 1'b1; i_addr[0] = 32'h10;
    @(negedge clk);
    total++;
    if (i_gnt[0] !== 1'b1)
      $display("FAIL i_read_gnt: got %b want 1", i_gnt[0]);
    else passed++;
    nxt();
    i_req[0] = 1'b0;
    @(negedge clk);
    total++;
    if ({i_rvalid[0], i_rdata[0]} !== {1'b1, 32'h0000_0013})
      $display("FAIL i_read_data: got %b/%h want 1/00000013",
        i_rvalid[0], i_rdata[0]);
    else passed++;
    nxt();
  endtask

  task automatic test_starve();
    string exp_s = "DDDIDDDI";
    i_req[0] = 1'b1; i_addr[0] = 32'h40;
    d_req[0] = 1'b1; d_addr[0] = 32'h44; d_we[0] = 1'b0;
    for (int p = 0; p < 8; p++) begin
      logic want_i;
      @(negedge clk);
      want_i = (exp_s[p] == "I");
      total++;
      if ({i_gnt[0], d_gnt[0]} !== {want_i, !want_i})
        $display("FAIL starve_seq p%0d: got %b%b want %b%b", p,
          i_gnt[0], d_gnt[0], want_i, !want_i);
      else passed++;
      nxt();
    end
    idle_all();
    nxt();
  endtask

  task automatic test_write_merge();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h20;
    d_wmask[0] = 4'b1111; d_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (d_gnt[0] !== 1'b1)
      $display("FAIL wr1_gnt: got %b want 1", d_gnt[0]);
    else passed++;
    nxt();
    d_wmask[0] = 4'b0001; d_wdata[0] = 32'h0000_00AA;
    @(negedge clk);
    total++;
    if ({d_gnt[0], d_rvalid[0], d_rdata[0]} !== {2'b11, 32'h0})
      $display("FAIL wr1_ack: got %b%b/%h want 11/00000000",
        d_gnt[0], d_rvalid[0], d_rdata[0]);
    else passed++;
    nxt();
    d_we[0] = 1'b0; d_wmask[0] = 4'h0; d_wdata[0] = 32'h0;
    @(negedge clk);
    total++;
    if ({d_gnt[0], d_rvalid[0], d_rdata[0]} !== {2'b11, 32'h0})
      $display("FAIL wr2_ack: got %b%b/%h want 11/00000000",
        d_gnt[0], d_rvalid[0], d_rdata[0]);
    else passed++;
    nxt();
    d_req[0] = 1'b0;
    @(negedge clk);
    total++;
    if ({d_rvalid[0], d_rdata[0]} !== {1'b1, 32'hDEAD_BEAA})
      $display("FAIL merge_read: got %b/%h want 1/deadbeaa",
        d_rvalid[0], d_rdata[0]);
    else passed++;
    nxt();
  endtask

  task automatic test_reset_flush();
    i_req[0] = 1'b1; i_addr[0] = 32'h30;
    @(negedge clk);
    total++;
    if (i_gnt[0] !== 1'b1)
      $display("FAIL flush_gnt: got %b want 1", i_gnt[0]);
    else passed++;
    nxt();
    i_req[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (i_rvalid[0] !== 1'b0)
        $display("FAIL flush_drop c%0d: got %b want 0", c, i_rvalid[0]);
      else passed++;
      nxt();
    end
    i_req[0] = 1'b1; i_addr[0] = 32'h34;
    @(negedge clk);
    nxt();
    i_req[0] = 1'b0;
    @(negedge clk);
    total++;
    if ({i_rvalid[0], i_rdata[0]} !== {1'b1, init_word(13)})
      $display("FAIL flush_next: got %b/%h want 1/%h",
        i_rvalid[0], i_rdata[0], init_word(13));
    else passed++;
    nxt();
  endtask

  task automatic test_lat2();
    for (int p = 0; p < 10; p++) begin
      logic [65:0] er, ar;
      int s;
      i_req[1] = (p < 8) && (p % 2 == 0);
      d_req[1] = (p < 8) && (p % 2 == 1);
      d_we[1]  = 1'b0;
      i_addr[1] = 32'h200 + 32'(4 * p);
      d_addr[1] = 32'h200 + 32'(4 * p);
      @(negedge clk);
      if (p < 8) begin
        total++;
        if ({i_gnt[1], d_gnt[1]} !== {i_req[1], d_req[1]})
          $display("FAIL lat2_gnt p%0d: got %b%b want %b%b", p,
            i_gnt[1], d_gnt[1], i_req[1], d_req[1]);
        else passed++;
      end
      er = '0;
      s = p - 2;
      if (s >= 0 && s < 8)
        er = (s % 2 == 0) ? {1'b1, init_word(128 + s), 33'h0}
                          : {33'h0, 1'b1, init_word(128 + s)};
      ar = {i_rvalid[1], i_rdata[1], d_rvalid[1], d_rdata[1]};
      total++;
      if (ar !== er)
        $display("FAIL lat2_rsp p%0d: got %h want %h", p, ar, er);
      else passed++;
      nxt();
    end
    idle_all();
    nxt();
  endtask

  task automatic test_random();
    logic ig [2];
    logic dg [2];
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ig[k] = i_gnt[k]; dg[k] = d_gnt[k];
      end
      nxt();
      for (int k = 0; k < 2; k++) begin
        if (!i_req[k] || ig[k]) begin
          i_req[k]  = ($urandom_range(0, 99) < 60);
          i_addr[k] = 32'h100 + 32'(4 * $urandom_range(0, 15));
        end
        if (!d_req[k] || dg[k]) begin
          d_req[k]   = ($urandom_range(0, 99) < 55);
          d_we[k]    = $urandom_range(0, 1) == 1;
          d_wmask[k] = 4'($urandom);
          d_addr[k]  = 32'h100 + 32'(4 * $urandom_range(0, 15));
          d_wdata[k] = $urandom;
        end
      end
    end
    idle_all();
    for (int c = 0; c < 4; c++) nxt();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_i_read();
    test_starve();
    test_write_merge();
    test_reset_flush();
    test_lat2();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
